aes_512_ingress: RTL and testbench
==================================

# aes_512_ingress

Ingress stage directly upstream of the 512-bit four-lane AES cipher pipeline. The cipher has no backpressure and a fixed latency, and it applies its key port to every block in flight. This block therefore:
- converts a valid/ready 512-bit stream into the cipher's valid-only input;
- throttles issue with a credit counter that mirrors free space in the downstream egress FIFO;
- serialises key changes, applying a new key only at a packet boundary once the pipeline holds no in-flight blocks.

## Interface
Parameters:
- PIPE_LAT, 16: cipher input-to-output latency in cycles; also the drain length before a key change.
- CREDITS, 32: egress FIFO depth, which is the maximum number of beats in flight or buffered.
- CW, $clog2(CREDITS+1): credit counter width.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-high.
- s_data  in  512  input beat.
- s_valid  in  1  input beat valid.
- s_last  in  1  final beat of packet.
- s_ready  out  1  beat accepted when s_valid && s_ready.
- key_in  in  128  new key value.
- key_load  in  1  one-cycle pulse; capture key_in as pending key.
- key_busy  out  1  high while a pending key is not yet applied.
- key  out  128  registered key driven to the cipher.
- data_in  out  512  registered beat to the cipher.
- data_in_valid  out  1  beat valid to the cipher.
- data_in_last  out  1  last flag to the cipher.
- credit_return  in  1  pulse; egress FIFO popped one entry.
- credits  out  CW  current free credits.
- err_credit  out  1  sticky; credit_return received while credits==CREDITS.
- idle  out  1  state IDLE, no pending key, and the pipeline is empty.

## Operation
- States:
  - IDLE: between packets.
  - PKT: an accepted beat had s_last=0.
  - DRAIN: a key change is pending and the pipeline is being emptied.
- s_ready = (credits!=0) && state!=DRAIN && !(state==IDLE && key_busy). It depends on registers only, never on s_valid.
- Accepted beat:
  - registered into data_in and data_in_last; data_in_valid=1 on the next cycle, else 0;
  - IDLE→PKT if s_last=0;
  - PKT→IDLE if s_last=1 and no key is pending;
  - →DRAIN if s_last=1 and a key is pending.
- A single-beat packet (s_last=1 accepted in IDLE) stays in IDLE.
- key_load:
  - captures key_in into key_pend and sets key_busy;
  - in IDLE, next state is DRAIN;
  - in PKT, DRAIN is entered after the packet's last beat;
  - a repeated key_load overwrites key_pend (last wins).
- since_issue counter:
  - cleared to 0 on every cycle with data_in_valid=1;
  - otherwise increments, saturating at PIPE_LAT.
- DRAIN exits when since_issue==PIPE_LAT:
  - key<=key_pend, key_busy<=0, state<=IDLE;
  - if key_load coincides with this cycle, key<=key_in directly and key_busy<=0.
- Credits:
  - −1 on accept; +1 on credit_return;
  - both in the same cycle: unchanged;
  - credit_return at CREDITS is ignored and sets err_credit.
- Reset mid-packet: all state is discarded immediately and no partial packet is resumed.

## Timing
- Reset values:
  - outputs: data_in=0, data_in_valid=0, data_in_last=0, key=0, key_busy=0, credits=CREDITS, err_credit=0, idle=1, s_ready=1;
  - internal: since_issue=PIPE_LAT, state=IDLE.
- Accept-to-issue latency is exactly 1 cycle; back-to-back accepts give full throughput.
- A key change becomes visible on the key port no earlier than PIPE_LAT cycles after the last data_in_valid.
- Minimum key-change gap when already idle with an empty pipe:
  - key_load cycle t, DRAIN at t+1, key updated at the edge ending t+1;
  - s_ready reasserts at t+2.
- Credit updates are registered and affect s_ready on the following cycle.

## Structure
- Shared package aes_512_pkg holds DATA_W=512, KEY_W=128, AES_PIPE_LAT=16, and the ingress_state_t enum {IDLE, PKT, DRAIN}.
- One sub-module, aes_credit_counter: a saturating up/down counter with an overflow flag, reused by the egress FIFO side.

## Test plan
- Stream of 40 beats, s_valid constant, CREDITS=32, no credit_return → exactly 32 beats issued, s_ready=0 with credits=0; then one credit_return pulse → exactly one more beat issued.
- 3-beat packet, key_load pulsed during beat 2 → key unchanged through the last beat; s_ready=0 after it; key=new value exactly 16 cycles after the final data_in_valid.
- key_load of 0xA…A then 0xB…B on consecutive cycles in IDLE → key=0xB…B; 0xA…A never appears on key.
- credit_return and accept in the same cycle at credits=5 → credits stays 5; credit_return at credits=32 → err_credit=1 and stays high until rst.
- Assert rst mid-packet with credits=10 and key_busy=1 → outputs return to reset values asynchronously; a following packet starts in IDLE with credits=32.

Source files
------------

// File: rtl/aes_512_pkg.sv
// Shared definitions for the 512-bit four-lane AES datapath.
package aes_512_pkg;

    localparam int DATA_W       = 512;
    localparam int KEY_W        = 128;
    localparam int AES_PIPE_LAT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PKT   = 2'd1,
        DRAIN = 2'd2
    } ingress_state_t;

endpackage

// File: rtl/aes_credit_counter.sv
// Saturating up/down credit counter with a sticky overflow flag.
// Reset value is MAX (all credits free). An increment at MAX is dropped
// and flags overflow; a decrement at zero is dropped.
module aes_credit_counter #(
    parameter int MAX = 32,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         ovf
);

    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] ONE_V = W'(1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         ovf_q;
    logic         ovf_d;
    logic         inc_ok_s;
    logic         dec_ok_s;

    // Next count: apply legal increment/decrement, latch overflow on a dropped increment.
    always_comb begin
        count_d  = count_q;
        ovf_d    = ovf_q;
        inc_ok_s = inc && (count_q != MAX_V);
        dec_ok_s = dec && (count_q != {W{1'b0}});
        if (inc && (count_q == MAX_V)) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
        case ({inc_ok_s, dec_ok_s})
            2'b10:   count_d = count_q + ONE_V;
            2'b01:   count_d = count_q - ONE_V;
            default: count_d = count_q;
        endcase
    end

    // Counter and overflow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= MAX_V;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/aes_512_ingress.sv
// Ingress stage for the AES cipher pipeline: valid/ready to valid-only
// conversion, credit-based issue throttling and drained key changes.
module aes_512_ingress
    import aes_512_pkg::*;
#(
    parameter int PIPE_LAT = AES_PIPE_LAT,
    parameter int CREDITS  = 32,
    parameter int CW       = $clog2(CREDITS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              key_load,
    output logic              key_busy,
    output logic [KEY_W-1:0]  key,
    output logic [DATA_W-1:0] data_in,
    output logic              data_in_valid,
    output logic              data_in_last,
    input  logic              credit_return,
    output logic [CW-1:0]     credits,
    output logic              err_credit,
    output logic              idle
);

    localparam int            SW    = $clog2(PIPE_LAT + 1);
    localparam logic [SW-1:0] LAT_V = SW'(PIPE_LAT);
    localparam logic [SW-1:0] ONE_S = SW'(1);

    ingress_state_t    state_q, state_d;
    logic [SW-1:0]     since_issue_q, since_issue_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [KEY_W-1:0]  key_pend_q, key_pend_d;
    logic              key_busy_q, key_busy_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;

    logic              accept_s;
    logic              pending_s;
    logic              drain_done_s;

    // Credits mirror free egress FIFO entries; an accepted beat consumes one.
    aes_credit_counter #(
        .MAX (CREDITS),
        .W   (CW)
    ) u_credits (
        .clk   (clk),
        .rst   (rst),
        .inc   (credit_return),
        .dec   (accept_s),
        .count (credits),
        .ovf   (err_credit)
    );

    // Ready depends only on registered state so it never waits on s_valid.
    assign s_ready      = (credits != {CW{1'b0}}) && (state_q != DRAIN) &&
                          !((state_q == IDLE) && key_busy_q);
    assign accept_s     = s_valid && s_ready;
    assign pending_s    = key_busy_q || key_load;
    assign drain_done_s = (state_q == DRAIN) && (since_issue_q == LAT_V);

    // Next-state, beat capture, pipeline-empty tracking and key handoff.
    always_comb begin
        state_d       = state_q;
        since_issue_d = since_issue_q;
        key_d         = key_q;
        key_pend_d    = key_pend_q;
        key_busy_d    = key_busy_q;
        data_d        = data_q;
        valid_d       = 1'b0;
        last_d        = last_q;

        if (accept_s) begin
            data_d        = s_data;
            last_d        = s_last;
            valid_d       = 1'b1;
            since_issue_d = {SW{1'b0}};
        end else if (since_issue_q != LAT_V) begin
            since_issue_d = since_issue_q + ONE_S;
        end else begin
            since_issue_d = since_issue_q;
        end

        if (key_load) begin
            key_pend_d = key_in;
            key_busy_d = 1'b1;
        end else begin
            key_pend_d = key_pend_q;
        end

        case (state_q)
            IDLE: begin
                if (accept_s && !s_last) begin
                    state_d = PKT;
                end else if (pending_s) begin
                    state_d = DRAIN;
                end else begin
                    state_d = IDLE;
                end
            end
            PKT: begin
                if (accept_s && s_last) begin
                    state_d = pending_s ? DRAIN : IDLE;
                end else begin
                    state_d = PKT;
                end
            end
            DRAIN: begin
                if (drain_done_s) begin
                    // A key arriving on the exit cycle is newer than key_pend.
                    state_d    = IDLE;
                    key_d      = key_load ? key_in : key_pend_q;
                    key_busy_d = 1'b0;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            since_issue_q <= LAT_V;
            key_q         <= {KEY_W{1'b0}};
            key_pend_q    <= {KEY_W{1'b0}};
            key_busy_q    <= 1'b0;
            data_q        <= {DATA_W{1'b0}};
            valid_q       <= 1'b0;
            last_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            since_issue_q <= since_issue_d;
            key_q         <= key_d;
            key_pend_q    <= key_pend_d;
            key_busy_q    <= key_busy_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            last_q        <= last_d;
        end
    end

    assign key           = key_q;
    assign key_busy      = key_busy_q;
    assign data_in       = data_q;
    assign data_in_valid = valid_q;
    assign data_in_last  = last_q;
    assign idle          = (state_q == IDLE) && !key_busy_q && (since_issue_q == LAT_V);

endmodule

// File: tb/tb_aes_512_ingress.sv
// Self-checking bench for aes_512_ingress: a vector table, directed
// corner-case sequences and a randomized run against a reference model.
module tb_aes_512_ingress;

    localparam int LAT   = 16;
    localparam int NCRED = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] s_data;
    logic         s_valid, s_last, s_ready;
    logic [127:0] key_in, key;
    logic         key_load, key_busy;
    logic [511:0] data_in;
    logic         data_in_valid, data_in_last;
    logic         credit_return;
    logic [5:0]   credits;
    logic         err_credit, idle;

    int n_checks = 0;
    int n_pass   = 0;

    aes_512_ingress dut (
        .clk           (clk),
        .rst           (rst),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .key_in        (key_in),
        .key_load      (key_load),
        .key_busy      (key_busy),
        .key           (key),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_last  (data_in_last),
        .credit_return (credit_return),
        .credits       (credits),
        .err_credit    (err_credit),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s_data = '0; s_valid = 1'b0; s_last = 1'b0;
        key_in = '0; key_load = 1'b0; credit_return = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- reference model (cycle-level, abstract) ----------------
    int           m_credits, m_since;
    bit           m_err, m_inpkt, m_drain, m_busy, m_dv, m_dl;
    logic [127:0] m_key, m_pend;
    logic [511:0] m_dd;

    function automatic bit m_ready();
        return (m_credits != 0) && !m_drain && !(!m_inpkt && m_busy);
    endfunction

    task automatic model_reset();
        m_credits = NCRED; m_since = LAT; m_err = 0; m_inpkt = 0; m_drain = 0;
        m_busy = 0; m_dv = 0; m_dl = 0; m_key = '0; m_pend = '0; m_dd = '0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit acc, pending, done;
        acc     = s_valid && m_ready();
        pending = m_busy || key_load;
        done    = m_drain && (m_since == LAT);
        m_dv = acc;
        if (acc) begin m_dd = s_data; m_dl = s_last; end
        m_since = acc ? 0 : ((m_since < LAT) ? m_since + 1 : LAT);
        if (credit_return && m_credits == NCRED) m_err = 1;
        m_credits = m_credits - int'(acc) + int'(credit_return && m_credits != NCRED);
        if (done) begin
            m_key   = key_load ? key_in : m_pend;
            m_drain = 0;
            m_busy  = 0;
        end else if (m_drain) begin
            m_drain = 1;
        end else if (m_inpkt) begin
            if (acc && s_last) begin m_inpkt = 0; m_drain = pending; end
        end else begin
            if (acc && !s_last) m_inpkt = 1;
            else if (pending) m_drain = 1;
        end
        if (key_load) m_pend = key_in;
        if (!done && key_load) m_busy = 1;
    endtask

    task automatic model_check();
        chk("rnd_s_ready", s_ready, m_ready());
        chk("rnd_valid", data_in_valid, m_dv);
        if (m_dv) begin
            chk("rnd_data", data_in, m_dd);
            chk("rnd_last", data_in_last, m_dl);
        end
        chk("rnd_key", key, m_key);
        chk("rnd_busy", key_busy, m_busy);
        chk("rnd_credits", credits, m_credits);
        chk("rnd_err", err_credit, m_err);
        chk("rnd_idle", idle, !m_inpkt && !m_drain && !m_busy && m_since == LAT);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         sv, sl, kl, cr;
        logic [127:0] kin;
        logic         exp_ready, exp_valid, exp_last, exp_busy;
        int           exp_credits;
        logic [127:0] exp_key;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [127:0] k1, k2, ka, kb, kn;
        int cnt;
        bit ok, saw_a;

        k1 = {4{32'h1111_0001}}; k2 = {4{32'h2222_0002}};
        ka = {32{4'hA}};         kb = {32{4'hB}};
        kn = {4{32'h5EED_C0DE}};

        //           sv    sl    kl    cr    kin  rdy   vld   last  busy  cred  key
        tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, k1,  1'b0, 1'b0, 1'b0, 1'b1, 32, 128'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, k2,  1'b1, 1'b0, 1'b0, 1'b0, 32, k1};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, k2,  1'b1, 1'b1, 1'b1, 1'b0, 31, k1};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, k2,  1'b1, 1'b0, 1'b0, 1'b0, 32, k1};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, k2,  1'b1, 1'b1, 1'b0, 1'b1, 31, k1};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, k2,  1'b0, 1'b1, 1'b1, 1'b1, 30, k1};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, k2,  1'b0, 1'b0, 1'b0, 1'b1, 30, k1};

        // Reset values.
        do_reset();
        chk("rst_data", data_in, 512'd0);
        chk("rst_valid", data_in_valid, 1'b0);
        chk("rst_key", key, 128'd0);
        chk("rst_busy", key_busy, 1'b0);
        chk("rst_credits", credits, NCRED);
        chk("rst_err", err_credit, 1'b0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_ready", s_ready, 1'b1);

        // Table: minimal key-change gap, single-beat packet, key at packet start.
        for (int i = 0; i < 7; i++) begin
            s_valid = tbl[i].sv; s_last = tbl[i].sl; key_load = tbl[i].kl;
            key_in = tbl[i].kin; credit_return = tbl[i].cr;
            s_data = {16{32'hC0DE_0000 + 32'(i)}};
            step();
            chk($sformatf("tbl%0d_ready", i), s_ready, tbl[i].exp_ready);
            chk($sformatf("tbl%0d_valid", i), data_in_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) begin
                chk($sformatf("tbl%0d_last", i), data_in_last, tbl[i].exp_last);
                chk($sformatf("tbl%0d_data", i), data_in, {16{32'hC0DE_0000 + 32'(i)}});
            end
            chk($sformatf("tbl%0d_busy", i), key_busy, tbl[i].exp_busy);
            chk($sformatf("tbl%0d_credits", i), credits, tbl[i].exp_credits);
            chk($sformatf("tbl%0d_key", i), key, tbl[i].exp_key);
        end

        // Credit exhaustion: 40 offered beats, only 32 issued; one return frees one more.
        do_reset();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            s_valid = 1'b1; s_last = (i % 4 == 3); s_data = {16{32'(i)}};
            step();
            if (data_in_valid) cnt++;
        end
        chk("exhaust_issued", cnt, 32);
        chk("exhaust_ready", s_ready, 1'b0);
        chk("exhaust_credits", credits, 0);
        credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (data_in_valid) cnt++;
        end
        chk("one_credit_issued", cnt, 1);
        chk("one_credit_credits", credits, 0);
        s_valid = 1'b0;

        // Key load mid-packet: key held through the packet and PIPE_LAT cycles after it.
        do_reset();
        s_valid = 1'b1; s_last = 1'b0; s_data = {16{32'hBEA7_0001}};
        step();
        key_load = 1'b1; key_in = kn; s_data = {16{32'hBEA7_0002}};
        step();
        key_load = 1'b0;
        chk("midpkt_key_beat2", key, 128'd0);
        s_last = 1'b1; s_data = {16{32'hBEA7_0003}};
        step();
        s_valid = 1'b0; s_last = 1'b0;
        chk("midpkt_final_valid", data_in_valid, 1'b1);
        chk("midpkt_final_last", data_in_last, 1'b1);
        chk("midpkt_key_last", key, 128'd0);
        chk("midpkt_ready_low", s_ready, 1'b0);
        ok = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            step();
            if (key !== 128'd0) ok = 1'b0;
        end
        chk("midpkt_key_held", ok, 1'b1);
        step();
        chk("midpkt_key_new", key, kn);
        chk("midpkt_busy_clear", key_busy, 1'b0);
        chk("midpkt_ready_back", s_ready, 1'b1);

        // Back-to-back key loads in IDLE: last one wins, first never reaches key.
        do_reset();
        key_load = 1'b1; key_in = ka;
        step();
        saw_a = (key === ka);
        key_in = kb;
        step();
        key_load = 1'b0;
        saw_a = saw_a || (key === ka);
        chk("kk_key_b", key, kb);
        chk("kk_busy", key_busy, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            if (key === ka) saw_a = 1'b1;
        end
        chk("kk_never_a", saw_a, 1'b0);
        chk("kk_key_stays_b", key, kb);

        // Simultaneous accept and return; overflowing return sets sticky error.
        do_reset();
        s_valid = 1'b1; s_last = 1'b1;
        for (int i = 0; i < 27; i++) step();
        chk("cr_at5", credits, 5);
        credit_return = 1'b1;
        step();
        chk("cr_same_cycle", credits, 5);
        s_valid = 1'b0; s_last = 1'b0;
        for (int i = 0; i < 27; i++) step();
        chk("cr_full", credits, NCRED);
        chk("cr_no_err_yet", err_credit, 1'b0);
        step();
        credit_return = 1'b0;
        chk("cr_overflow_err", err_credit, 1'b1);
        chk("cr_overflow_credits", credits, NCRED);
        for (int i = 0; i < 5; i++) step();
        chk("cr_err_sticky", err_credit, 1'b1);

        // Asynchronous reset in the middle of a packet with a key pending.
        s_valid = 1'b1; s_last = 1'b0;
        for (int i = 0; i < 22; i++) begin
            key_load = (i == 10); key_in = kn;
            step();
        end
        key_load = 1'b0;
        chk("midrst_credits_before", credits, 10);
        chk("midrst_busy_before", key_busy, 1'b1);
        #2;
        s_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_data", data_in, 512'd0);
        chk("arst_valid", data_in_valid, 1'b0);
        chk("arst_last", data_in_last, 1'b0);
        chk("arst_key", key, 128'd0);
        chk("arst_busy", key_busy, 1'b0);
        chk("arst_credits", credits, NCRED);
        chk("arst_err", err_credit, 1'b0);
        chk("arst_idle", idle, 1'b1);
        chk("arst_ready", s_ready, 1'b1);
        step();
        rst = 1'b0;
        s_valid = 1'b1; s_last = 1'b1; s_data = {16{32'hFEED_F00D}};
        step();
        s_valid = 1'b0; s_last = 1'b0;
        chk("post_rst_valid", data_in_valid, 1'b1);
        chk("post_rst_credits", credits, NCRED - 1);
        step();
        chk("post_rst_ready", s_ready, 1'b1);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            s_valid       = ($urandom_range(0, 3) != 0);
            s_last        = ($urandom_range(0, 3) == 0);
            s_data        = rnd512();
            key_load      = ($urandom_range(0, 24) == 0);
            key_in        = {$urandom, $urandom, $urandom, $urandom};
            credit_return = ((m_credits < NCRED) && ($urandom_range(0, 1) == 1)) ||
                            ($urandom_range(0, 499) == 0);
            model_step();
            step();
            model_check();
        end
        clear_inputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
